// File: rtl/board_link_pkg.sv
// Shared types and helpers for the serial board-to-board link.
package board_link_pkg;

  localparam int unsigned SYNC_STAGES = 2;

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP} rx_state_t;

  // Bits per frame: start + data + parity + stop + idle gap.
  function automatic int unsigned frame_bits(input int unsigned data_w,
                                             input int unsigned idle_bits);
    return data_w + 3 + idle_bits;
  endfunction

endpackage

// File: rtl/board_link_rx.sv
// Receive half: input synchroniser, frame deserialiser, parity/stop check
// and link-liveness timeout.
module board_link_rx
  import board_link_pkg::*;
#(
  parameter int unsigned       DATA_W       = 12,
  parameter int unsigned       CLKS_PER_BIT = 100,
  parameter int unsigned       LINK_TIMEOUT = 1_000_000,
  parameter logic [DATA_W-1:0] RX_DEFAULT   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_serial,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_err,
  output logic              link_up
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_W + 1);
  localparam int unsigned TMO_W = $clog2(LINK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(LINK_TIMEOUT);

  logic [SYNC_STAGES-1:0] sync;
  logic                   line;
  logic                   prev;
  logic                   fall;

  rx_state_t         state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [BIT_W-1:0]  bit_idx, bit_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [DATA_W-1:0] data_n;
  logic              par_bit, par_n;
  logic              valid_n, err_n;
  logic [TMO_W-1:0]  tmo;

  assign line = sync[SYNC_STAGES-1];
  assign fall = prev & ~line;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '1;
      prev <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx_serial};
      prev <= line;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_W'(1);
    bit_n   = bit_idx;
    shreg_n = shreg;
    par_n   = par_bit;
    data_n  = rx_data;
    valid_n = 1'b0;
    err_n   = 1'b0;
    case (state)
      R_IDLE: begin
        cnt_n = '0;
        if (fall) state_n = R_START;
      end
      R_START: begin
        // Mid-bit check rejects short glitches without flagging an error.
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = line ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          shreg_n = shreg >> 1;
          shreg_n[DATA_W-1] = line;
          if (bit_idx == DATA_LAST) state_n = R_PARITY;
          else bit_n = bit_idx + BIT_W'(1);
        end
      end
      R_PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          par_n   = line;
          state_n = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          state_n = R_IDLE;
          if (line && ((^shreg) == par_bit)) begin
            data_n  = shreg;
            valid_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      default: state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= R_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      rx_data  <= RX_DEFAULT;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      shreg    <= shreg_n;
      par_bit  <= par_n;
      rx_data  <= data_n;
      rx_valid <= valid_n;
      rx_err   <= err_n;
    end
  end

  // Saturating timeout; only good frames refresh it.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo     <= '0;
      link_up <= 1'b0;
    end else if (valid_n) begin
      tmo     <= '0;
      link_up <= 1'b1;
    end else if (tmo != TMO_MAX) begin
      tmo <= tmo + TMO_W'(1);
      if (tmo == TMO_MAX - TMO_W'(1)) link_up <= 1'b0;
    end
  end

endmodule

// File: rtl/board_link_serdes.sv
// Serial board-to-board link: free-running frame transmitter plus the
// receive/liveness path in board_link_rx.
module board_link_serdes
  import board_link_pkg::*;
#(
  parameter int unsigned       DATA_W       = 12,
  parameter int unsigned       CLKS_PER_BIT = 100,
  parameter int unsigned       IDLE_BITS    = 2,
  parameter int unsigned       LINK_TIMEOUT = 1_000_000,
  parameter logic [DATA_W-1:0] RX_DEFAULT   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_frame_start,
  output logic              tx_serial,
  input  logic              rx_serial,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_err,
  output logic              link_up
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(frame_bits(DATA_W, IDLE_BITS));
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] IDLE_LAST = BIT_W'(IDLE_BITS - 1);

  tx_state_t         state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [BIT_W-1:0]  bit_idx, bit_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              parity, parity_n;
  logic              serial_n, start_n;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt + CNT_W'(1);
    bit_n    = bit_idx;
    shreg_n  = shreg;
    parity_n = parity;
    start_n  = 1'b0;
    serial_n = 1'b1;
    if (cnt == CNT_LAST) begin
      cnt_n = '0;
      case (state)
        T_IDLE: begin
          if (bit_idx == IDLE_LAST) begin
            state_n  = T_START;
            bit_n    = '0;
            shreg_n  = tx_data;
            parity_n = ^tx_data;
            start_n  = 1'b1;
          end else begin
            bit_n = bit_idx + BIT_W'(1);
          end
        end
        T_START: begin
          state_n = T_DATA;
          bit_n   = '0;
        end
        T_DATA: begin
          if (bit_idx == DATA_LAST) begin
            state_n = T_PARITY;
            bit_n   = '0;
          end else begin
            bit_n   = bit_idx + BIT_W'(1);
            shreg_n = shreg >> 1;
          end
        end
        T_PARITY: state_n = T_STOP;
        T_STOP: begin
          state_n = T_IDLE;
          bit_n   = '0;
        end
        default: state_n = T_IDLE;
      endcase
    end
    // Line level follows the state being entered so tx_serial is registered.
    case (state_n)
      T_START:  serial_n = 1'b0;
      T_DATA:   serial_n = shreg_n[0];
      T_PARITY: serial_n = parity_n;
      default:  serial_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= T_IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      shreg          <= '0;
      parity         <= 1'b0;
      tx_serial      <= 1'b1;
      tx_frame_start <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      bit_idx        <= bit_n;
      shreg          <= shreg_n;
      parity         <= parity_n;
      tx_serial      <= serial_n;
      tx_frame_start <= start_n;
    end
  end

  board_link_rx #(
    .DATA_W       (DATA_W),
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .LINK_TIMEOUT (LINK_TIMEOUT),
    .RX_DEFAULT   (RX_DEFAULT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx_serial (rx_serial),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_err    (rx_err),
    .link_up   (link_up)
  );

endmodule

// File: tb/tb_board_link_serdes.sv
// Loopback bench for board_link_serdes with a frame-level reference model.
module tb_board_link_serdes;

  localparam int DW    = 12;
  localparam int CPB   = 8;
  localparam int IDLE  = 2;
  localparam int LT    = 1000;
  localparam int FRAME = (DW + 3 + IDLE) * CPB;
  localparam int FIRST = IDLE * CPB;
  localparam int LAT   = 2 + 1 + CPB / 2 + (DW + 2) * CPB;
  localparam logic [DW-1:0] RXD = 12'h000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] tx_data = 12'hA5C;
  logic          tx_frame_start, tx_serial, rx_serial;
  logic [DW-1:0] rx_data;
  logic          rx_valid, rx_err, link_up;

  int   checks = 0;
  int   errors = 0;
  int   k = 0;
  logic rst_q = 1'b1;
  logic [DW-1:0] tx_q = '0;
  int   line_mode = 0;  // 0 loopback, 1 loopback with parity flipped, 2 held high
  logic glitch = 1'b0;
  logic flip = 1'b0;

  assign rx_serial = glitch ? 1'b0 : (line_mode == 2) ? 1'b1 : (tx_serial ^ flip);

  board_link_serdes #(
    .DATA_W       (DW),
    .CLKS_PER_BIT (CPB),
    .IDLE_BITS    (IDLE),
    .LINK_TIMEOUT (LT),
    .RX_DEFAULT   (RXD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .tx_data        (tx_data),
    .tx_frame_start (tx_frame_start),
    .tx_serial      (tx_serial),
    .rx_serial      (rx_serial),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_err         (rx_err),
    .link_up        (link_up)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, k);
    end
  endtask

  always @(posedge clk) begin
    rst_q <= reset;
    tx_q  <= tx_data;
    k     <= reset ? 0 : k + 1;
  end

  typedef struct {
    int          due;
    bit          is_err;
    logic [DW-1:0] data;
  } ev_t;

  ev_t           evq[$];
  logic [DW-1:0] cur_word = '0;
  logic          cur_par = 1'b0;
  int            frame_mode_cur = 0;
  logic [DW-1:0] exp_data = RXD;
  bit            seen = 1'b0;
  int            last_v = 0;
  int            err_seen = 0;

  always @(negedge clk) begin
    int   p, b;
    logic exp_ser, exp_start;
    ev_t  ev;
    if (rst_q) begin
      evq.delete();
      seen     = 1'b0;
      exp_data = RXD;
      flip     = 1'b0;
      chk("reset_tx_serial", tx_serial, 1);
      chk("reset_frame_start", tx_frame_start, 0);
      chk("reset_rx_valid", rx_valid, 0);
      chk("reset_rx_err", rx_err, 0);
      chk("reset_link_up", link_up, 0);
      chk("reset_rx_data", rx_data, RXD);
    end else begin
      exp_ser   = 1'b1;
      exp_start = 1'b0;
      flip      = 1'b0;
      if (k >= FIRST) begin
        p = (k - FIRST) % FRAME;
        b = p / CPB;
        if (p == 0) begin
          exp_start      = 1'b1;
          cur_word       = tx_q;
          cur_par        = ^tx_q;
          frame_mode_cur = line_mode;
          if (line_mode != 2)
            evq.push_back('{due: k + LAT, is_err: (line_mode == 1), data: tx_q});
        end
        if (b == 0) exp_ser = 1'b0;
        else if (b <= DW) exp_ser = cur_word[b-1];
        else if (b == DW + 1) exp_ser = cur_par;
        flip = (frame_mode_cur == 1) && (b == DW + 1);
      end
      chk("tx_serial", tx_serial, exp_ser);
      chk("tx_frame_start", tx_frame_start, exp_start);
      chk("valid_err_exclusive", rx_valid & rx_err, 0);
      if (rx_valid || rx_err) begin
        if (evq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rx_event: got valid=%0b err=%0b, required none (cycle %0d)",
                   rx_valid, rx_err, k);
        end else begin
          ev = evq.pop_front();
          chk("rx_event_kind_err", rx_err, ev.is_err);
          chk("rx_event_latency_ok", (k >= ev.due - 1) && (k <= ev.due + 1), 1);
          if (rx_valid && !ev.is_err) exp_data = ev.data;
        end
        if (rx_valid) begin
          seen   = 1'b1;
          last_v = k;
        end
        if (rx_err) err_seen++;
      end
      if (evq.size() > 0 && k > evq[0].due + 1) begin
        checks++;
        errors++;
        $display("FAIL missed_rx_event: got none, required err=%0b by cycle %0d (cycle %0d)",
                 evq[0].is_err, evq[0].due + 1, k);
        void'(evq.pop_front());
      end
      chk("rx_data", rx_data, exp_data);
      chk("link_up", link_up, seen && (k - last_v < LT));
    end
  end

  task automatic wait_start(output int at);
    at = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (tx_frame_start === 1'b1) begin
        at = k;
        break;
      end
    end
    if (at < 0) chk("timeout_frame_start", 0, 1);
  endtask

  task automatic wait_valid(output int at);
    at = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (rx_valid === 1'b1) begin
        at = k;
        break;
      end
    end
    if (at < 0) chk("timeout_rx_valid", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish by 1000000");
    $fatal(1);
  end

  initial begin
    int s0, s1, s3, s5, s7, s8, v0, v1, v2, v4, v6, v8, fall;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    wait_start(s0);
    chk("first_start_delay", s0, 16);
    wait_valid(v0);
    chk("first_latency_window", (v0 - s0 >= 118) && (v0 - s0 <= 120), 1);
    chk("first_data", rx_data, 12'hA5C);
    chk("link_after_first", link_up, 1);
    wait_start(s1);
    chk("frame_period", s1 - s0, 136);

    @(posedge clk);
    #1 tx_data = 12'h3F0;
    wait_valid(v1);
    chk("frame_before_change", rx_data, 12'hA5C);
    wait_valid(v2);
    chk("frame_after_change", rx_data, 12'h3F0);

    repeat (5) @(posedge clk);
    #1 line_mode = 1;
    wait_start(s3);
    repeat (124) @(posedge clk);
    #1 line_mode = 0;
    chk("parity_err_count", err_seen, 1);
    chk("data_held_after_err", rx_data, 12'h3F0);
    chk("link_kept_after_err", link_up, 1);
    wait_valid(v4);
    chk("clean_after_err", rx_data, 12'h3F0);

    repeat (5) @(posedge clk);
    #1 line_mode = 2;
    repeat (300) @(posedge clk);
    #1 glitch = 1'b1;
    repeat (2) @(posedge clk);
    #1 glitch = 1'b0;
    fall = -1;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      if (link_up === 1'b0) begin
        fall = k;
        break;
      end
    end
    chk("link_timeout_cycles", fall - v4, 1000);
    chk("data_held_after_timeout", rx_data, 12'h3F0);

    wait_start(s5);
    repeat (124) @(posedge clk);
    #1 line_mode = 0;
    wait_valid(v6);
    chk("frame_after_glitch", rx_data, 12'h3F0);
    chk("link_back_up", link_up, 1);
    chk("no_err_from_glitch", err_seen, 1);

    wait_start(s7);
    repeat (40) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_mid_frame_tx_serial", tx_serial, 1);
    chk("reset_mid_frame_rx_data", rx_data, 12'h000);
    reset = 1'b0;
    wait_start(s8);
    chk("start_after_reset", s8, 16);
    wait_valid(v8);
    chk("frame_after_reset", rx_data, 12'h3F0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
